// File: rtl/shift_cmd_sequencer.sv
// Command FIFO + registered result stage wrapped around an external barrel shifter.
// Optional saturating stall/hold counters when SHIFT_SEQ_STATS_EN is defined.
module shift_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int AW    = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_data,
    input  logic [AW-1:0]            in_amt,
    output logic [DW-1:0]            sh_x,
    output logic [AW-1:0]            sh_amt,
    input  logic [DW-1:0]            sh_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(DEPTH):0]   count
`ifdef SHIFT_SEQ_STATS_EN
    ,
    output logic [7:0]               stall_cnt,
    output logic [7:0]               hold_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        S_EMPTY,
        S_FULL
    } out_state_t;

    out_state_t r_state;
    out_state_t w_state_nxt;

    logic [DW-1:0] r_mem_d [DEPTH];
    logic [AW-1:0] r_mem_a [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_out_data;

    logic w_has_head;
    logic w_in_ready;
    logic w_push;
    logic w_pop;

    assign w_has_head = (r_count != '0);
    assign w_in_ready = (r_count < CW'(DEPTH)) && !reset;
    assign w_push     = in_valid && w_in_ready;
    assign w_pop      = w_has_head && ((r_state == S_EMPTY) || out_ready);

    assign in_ready  = w_in_ready;
    assign count     = r_count;
    assign out_valid = (r_state == S_FULL);
    assign out_data  = r_out_data;
    assign sh_x      = (w_has_head && !reset) ? r_mem_d[r_rd_ptr] : '0;
    assign sh_amt    = (w_has_head && !reset) ? r_mem_a[r_rd_ptr] : '0;

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_d[r_wr_ptr] <= in_data;
            r_mem_a[r_wr_ptr] <= in_amt;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_EMPTY;
            r_out_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_out_data <= sh_out;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_EMPTY: begin
                if (w_pop) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (out_ready && !w_has_head) begin
                    w_state_nxt = S_EMPTY;
                end
            end
        endcase
    end

`ifdef SHIFT_SEQ_STATS_EN
    logic [7:0] r_stall_cnt;
    logic [7:0] r_hold_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_hold_cnt  <= '0;
        end else begin
            if (in_valid && !w_in_ready && (r_stall_cnt != 8'hFF)) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end
            if (out_valid && !out_ready && (r_hold_cnt != 8'hFF)) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign hold_cnt  = r_hold_cnt;
`endif

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer with a rotate-left shifter stub.
// Define SHIFT_SEQ_STATS_EN to also exercise the stall/hold counters.
module tb_shift_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [AW-1:0] in_amt = '0;
    logic [DW-1:0] sh_x;
    logic [AW-1:0] sh_amt;
    logic [DW-1:0] sh_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [2:0]    count;
`ifdef SHIFT_SEQ_STATS_EN
    logic [7:0]    stall_cnt;
    logic [7:0]    hold_cnt;
`endif

    always #5 clk = ~clk;

    shift_cmd_sequencer #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .sh_x      (sh_x),
        .sh_amt    (sh_amt),
        .sh_out    (sh_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
`ifdef SHIFT_SEQ_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .hold_cnt  (hold_cnt)
`endif
    );

    // Shifter stub: rotate left via doubled word.
    logic [15:0] w_dbl;
    assign w_dbl  = {sh_x, sh_x} << sh_amt;
    assign sh_out = w_dbl[15:8];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_rotl(input logic [7:0] x,
                                              input logic [2:0] a);
        logic [7:0] r;
        r = x;
        for (int k = 0; k < int'(a); k++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Scoreboard: every accepted command must come out once, in order.
    logic [7:0] exp_q[$];
    int n_cons = 0;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            chk("occupancy", 32'(count) + 32'(out_valid), 32'(exp_q.size()));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_result", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("order", 32'(out_data), 32'(exp_q.pop_front()));
                    n_cons++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model_rotl(in_data, in_amt));
        end
    end

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic [2:0] a;
        logic       ordy;
        logic       e_ov;
        logic [7:0] e_od;
        logic [2:0] e_cnt;
        logic       e_ir;
    } vec_t;

    vec_t vt[11];
    logic [7:0] sexp[8];

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (count == 0 && !out_valid) break;
        end
        chk("drain_idle", 32'(count == 0 && !out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        int n_start;

        vt[0]  = '{1'b1, 8'h01, 3'd0, 1'b0, 1'b0, 8'h00, 3'd1, 1'b1};
        vt[1]  = '{1'b1, 8'h01, 3'd1, 1'b0, 1'b1, 8'h01, 3'd1, 1'b1};
        vt[2]  = '{1'b1, 8'h01, 3'd2, 1'b0, 1'b1, 8'h01, 3'd2, 1'b1};
        vt[3]  = '{1'b1, 8'h01, 3'd3, 1'b0, 1'b1, 8'h01, 3'd3, 1'b1};
        vt[4]  = '{1'b1, 8'h01, 3'd4, 1'b0, 1'b1, 8'h01, 3'd4, 1'b0};
        vt[5]  = '{1'b1, 8'h55, 3'd0, 1'b0, 1'b1, 8'h01, 3'd4, 1'b0};
        vt[6]  = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 8'h02, 3'd3, 1'b1};
        vt[7]  = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1};
        vt[8]  = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 8'h08, 3'd1, 1'b1};
        vt[9]  = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 8'h10, 3'd0, 1'b1};
        vt[10] = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 8'h10, 3'd0, 1'b1};
        sexp = '{8'hF0, 8'hE1, 8'hC3, 8'h87, 8'h0F, 8'h1E, 8'h3C, 8'h78};

        // Reset state while held
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_sh_x", 32'(sh_x), 32'd0);
        reset = 1'b0;
        #1 chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Single command latency
        in_valid = 1'b1; in_data = 8'h81; in_amt = 3'd1; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("single_cnt", 32'(count), 32'd1);
        chk("single_ov_n", 32'(out_valid), 32'd0);
        chk("single_sh_x", 32'(sh_x), 32'h81);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("single_ov_n1", 32'(out_valid), 32'd1);
        chk("single_od_n1", 32'(out_data), 32'h03);
        @(posedge clk); #1;
        chk("single_ov_n2", 32'(out_valid), 32'd0);

        // Fill and back-pressure table
        do_reset();
        foreach (vt[i]) begin
            in_valid = vt[i].iv; in_data = vt[i].d;
            in_amt = vt[i].a; out_ready = vt[i].ordy;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_ov", i), 32'(out_valid), 32'(vt[i].e_ov));
            chk($sformatf("tbl%0d_od", i), 32'(out_data), 32'(vt[i].e_od));
            chk($sformatf("tbl%0d_cnt", i), 32'(count), 32'(vt[i].e_cnt));
            chk($sformatf("tbl%0d_ir", i), 32'(in_ready), 32'(vt[i].e_ir));
        end

        // Streaming, one result per cycle
        out_ready = 1'b1; in_data = 8'hF0;
        for (int j = 0; j < 10; j++) begin
            in_valid = (j < 8);
            in_amt = AW'(j);
            @(posedge clk); #1;
            chk("stream_cnt_le1", 32'(count <= 1), 32'd1);
            if (j >= 1 && j <= 8) begin
                chk("stream_ov", 32'(out_valid), 32'd1);
                chk("stream_od", 32'(out_data), 32'(sexp[j-1]));
            end
        end
        chk("stream_end_ov", 32'(out_valid), 32'd0);

        // Wrap-around with alternating out_ready
        pushed = 0;
        n_start = n_cons;
        for (int c = 0; c < 200; c++) begin
            in_valid = (pushed < 10);
            in_data = 8'($urandom);
            in_amt = AW'($urandom);
            out_ready = c[0];
            #1;
            if (in_valid && in_ready) pushed++;
            @(posedge clk); #1;
            if (pushed == 10 && n_cons - n_start == 10) break;
        end
        chk("wrap_consumed", 32'(n_cons - n_start), 32'd10);
        drain();

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 400; c++) begin
            in_valid = 1'($urandom);
            in_data = 8'($urandom);
            in_amt = AW'($urandom);
            out_ready = ($urandom_range(3) != 0);
            @(posedge clk); #1;
        end
        drain();
        chk("rand_all_out", 32'(exp_q.size()), 32'd0);

        // Reset mid-operation
        in_valid = 1'b1; out_ready = 1'b0; in_data = 8'h3C; in_amt = 3'd2;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_ov", 32'(out_valid), 32'd0);
        chk("mid_rst_od", 32'(out_data), 32'd0);
        chk("mid_rst_cnt", 32'(count), 32'd0);
        chk("mid_rst_ir", 32'(in_ready), 32'd0);
        chk("mid_rst_sh", 32'({sh_x, sh_amt}), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("mid_rel_ir", 32'(in_ready), 32'd1);
        chk("mid_rel_ov", 32'(out_valid), 32'd0);

`ifdef SHIFT_SEQ_STATS_EN
        // Saturating stall/hold counters
        in_valid = 1'b1; out_ready = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("stats_stall_sat", 32'(stall_cnt), 32'hFF);
        chk("stats_hold_sat", 32'(hold_cnt), 32'hFF);
        reset = 1'b1;
        #1;
        chk("stats_stall_rst", 32'(stall_cnt), 32'd0);
        chk("stats_hold_rst", 32'(hold_cnt), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
